// File: rtl/fft8_frame_sequencer_pkg.sv
// Shared state encoding, constants and bin-order helper for the FFT-8 frame sequencer.
package fft8_frame_sequencer_pkg;

   typedef enum logic [2:0] {
      S_LOAD    = 3'd0,
      S_LAUNCH  = 3'd1,
      S_WAIT_UP = 3'd2,
      S_WAIT_DN = 3'd3,
      S_UNLOAD  = 3'd4
   } state_t;

   localparam logic       HIGH     = 1'b1;
   localparam logic       LOW      = 1'b0;
   localparam int         FFT_N    = 8;
   localparam logic [2:0] LAST_IDX = 3'(FFT_N - 1);

   function automatic logic [2:0] bitrev3(input logic [2:0] idx);
      return {idx[0], idx[1], idx[2]};
   endfunction

endpackage

// File: rtl/fft8_frame_sequencer.sv
// Frame scheduler around fft8_controller: loads x_0..x_7 from a valid/ready stream,
// launches the transform, waits for it to finish and streams the 8 bins back out.
module fft8_frame_sequencer
   import fft8_frame_sequencer_pkg::*;
#(
   parameter int DATA_W        = 16,
   parameter int START_TIMEOUT = 4,
   parameter int BIT_REV_OUT   = 0
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                in_valid_i,
   input  logic [DATA_W-1:0]   in_data_i,
   output logic                in_ready_o,
   output logic [7:0]          x_wr_en_o,
   output logic [DATA_W-1:0]   x_wr_data_o,
   output logic                fft_start_o,
   input  logic                fft_busy_i,
   output logic [2:0]          res_sel_o,
   input  logic [2*DATA_W-1:0] res_data_i,
   output logic                out_valid_o,
   output logic [2*DATA_W-1:0] out_data_o,
   output logic                out_last_o,
   input  logic                out_ready_i,
   output logic                busy_o,
   output logic                err_o
);

   localparam int               TMR_W    = $clog2(START_TIMEOUT) + 1;
   localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(START_TIMEOUT - 1);

   // Both stream ports use plain valid/ready: a beat moves on any edge where
   // valid and ready are both high; a raised valid holds its data until then.

   state_t              state, state_n;
   logic [2:0]          load_cnt, load_cnt_n;
   logic [2:0]          out_cnt, out_cnt_n;
   logic                out_done, out_done_n;
   logic [TMR_W-1:0]    timer, timer_n;
   logic                err_n;
   logic                out_valid_n, out_last_n;
   logic [2*DATA_W-1:0] out_data_n;
   logic                out_fire;

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= S_LOAD;
         load_cnt    <= '0;
         out_cnt     <= '0;
         out_done    <= LOW;
         timer       <= '0;
         err_o       <= LOW;
         out_valid_o <= LOW;
         out_last_o  <= LOW;
         out_data_o  <= '0;
      end else begin
         state       <= state_n;
         load_cnt    <= load_cnt_n;
         out_cnt     <= out_cnt_n;
         out_done    <= out_done_n;
         timer       <= timer_n;
         err_o       <= err_n;
         out_valid_o <= out_valid_n;
         out_last_o  <= out_last_n;
         out_data_o  <= out_data_n;
      end
   end

   always_comb begin
      state_n     = state;
      load_cnt_n  = load_cnt;
      out_cnt_n   = out_cnt;
      out_done_n  = out_done;
      timer_n     = timer;
      err_n       = err_o;
      out_valid_n = out_valid_o;
      out_last_n  = out_last_o;
      out_data_n  = out_data_o;
      in_ready_o  = LOW;
      x_wr_en_o   = '0;
      x_wr_data_o = in_data_i;
      fft_start_o = LOW;
      res_sel_o   = '0;
      busy_o      = HIGH;
      out_fire    = out_valid_o & out_ready_i;

      case (state)
         S_LOAD: begin
            in_ready_o = HIGH;
            busy_o     = (load_cnt != 3'd0);
            if (in_valid_i) begin
               x_wr_en_o = 8'd1 << load_cnt;
               if (load_cnt == LAST_IDX) begin
                  load_cnt_n = '0;
                  state_n    = S_LAUNCH;
               end else begin
                  load_cnt_n = load_cnt + 3'd1;
               end
            end
         end
         S_LAUNCH: begin
            fft_start_o = HIGH;
            timer_n     = '0;
            state_n     = S_WAIT_UP;
         end
         S_WAIT_UP: begin
            // The controller registers start, so busy shows up a cycle or two late.
            if (fft_busy_i) begin
               state_n = S_WAIT_DN;
            end else if (timer == TMR_LAST) begin
               err_n   = HIGH;
               state_n = S_LOAD;
            end else begin
               timer_n = timer + TMR_W'(1);
            end
         end
         S_WAIT_DN: begin
            if (!fft_busy_i) begin
               out_cnt_n  = '0;
               out_done_n = LOW;
               state_n    = S_UNLOAD;
            end
         end
         S_UNLOAD: begin
            res_sel_o = (BIT_REV_OUT != 0) ? bitrev3(out_cnt) : out_cnt;
            // Single output slot: refill whenever it is empty or draining this cycle.
            if ((!out_valid_o || out_fire) && !out_done) begin
               out_data_n  = res_data_i;
               out_valid_n = HIGH;
               out_last_n  = (out_cnt == LAST_IDX);
               if (out_cnt == LAST_IDX) out_done_n = HIGH;
               else                     out_cnt_n  = out_cnt + 3'd1;
            end
            if (out_fire && out_last_o) begin
               out_valid_n = LOW;
               out_last_n  = LOW;
               state_n     = S_LOAD;
            end
         end
         default: state_n = S_LOAD;
      endcase
   end

endmodule

// File: tb/tb_fft8_frame_sequencer.sv
// Self-checking bench for fft8_frame_sequencer: natural-order and bit-reversed instances
// share stimulus; a busy model stands in for fft8_controller.
module tb_fft8_frame_sequencer;

   localparam int DATA_W        = 16;
   localparam int W2            = 2 * DATA_W;
   localparam int START_TIMEOUT = 4;
   localparam int BUSY_LEN      = 18;

   typedef struct {
      logic              in_valid;
      logic [DATA_W-1:0] in_data;
      logic              force_busy;
      logic [7:0]        exp_wr_en;
      logic              exp_ready;
      logic              exp_busy;
   } vec_t;

   logic              clk = 1'b0;
   logic              rst, in_valid, out_ready, fft_busy;
   logic [DATA_W-1:0] in_data;
   logic              in_ready, fft_start, out_valid, out_last, busy, err;
   logic [7:0]        x_wr_en;
   logic [DATA_W-1:0] x_wr_data;
   logic [2:0]        res_sel;
   logic [W2-1:0]     res_data, out_data;
   logic              rev_in_ready, rev_fft_start, rev_out_valid, rev_out_last, rev_busy, rev_err;
   logic [7:0]        rev_x_wr_en;
   logic [DATA_W-1:0] rev_x_wr_data;
   logic [2:0]        rev_res_sel;
   logic [W2-1:0]     rev_res_data, rev_out_data;

   logic [W2-1:0] bin_tbl [8];
   logic          force_busy;
   int            busy_mode, rise_dly;
   int            bm_t = 0;
   int            start_cnt = 0;
   int            frame_base;
   int            checks = 0;
   int            errors = 0;
   logic          exp_err;
   logic [W2-1:0] exp_q[$];
   logic [W2-1:0] exp_rev_q[$];
   int            beat, first_cyc, last_cyc;
   bit            stall_prev;
   logic [W2-1:0] data_prev, rev_data_prev;

   always #5 clk = ~clk;

   fft8_frame_sequencer #(.DATA_W(DATA_W), .START_TIMEOUT(START_TIMEOUT), .BIT_REV_OUT(0)) dut (
      .clk(clk), .rst(rst), .in_valid_i(in_valid), .in_data_i(in_data), .in_ready_o(in_ready),
      .x_wr_en_o(x_wr_en), .x_wr_data_o(x_wr_data), .fft_start_o(fft_start), .fft_busy_i(fft_busy),
      .res_sel_o(res_sel), .res_data_i(res_data), .out_valid_o(out_valid), .out_data_o(out_data),
      .out_last_o(out_last), .out_ready_i(out_ready), .busy_o(busy), .err_o(err));

   fft8_frame_sequencer #(.DATA_W(DATA_W), .START_TIMEOUT(START_TIMEOUT), .BIT_REV_OUT(1)) dut_rev (
      .clk(clk), .rst(rst), .in_valid_i(in_valid), .in_data_i(in_data), .in_ready_o(rev_in_ready),
      .x_wr_en_o(rev_x_wr_en), .x_wr_data_o(rev_x_wr_data), .fft_start_o(rev_fft_start),
      .fft_busy_i(fft_busy), .res_sel_o(rev_res_sel), .res_data_i(rev_res_data),
      .out_valid_o(rev_out_valid), .out_data_o(rev_out_data), .out_last_o(rev_out_last),
      .out_ready_i(out_ready), .busy_o(rev_busy), .err_o(rev_err));

   // Datapath output mux and controller busy behaviour
   assign res_data     = bin_tbl[res_sel];
   assign rev_res_data = bin_tbl[rev_res_sel];
   assign fft_busy = force_busy |
                     ((busy_mode == 0) && (bm_t >= rise_dly) && (bm_t < rise_dly + BUSY_LEN));

   always @(posedge clk) begin
      if (rst)                          bm_t <= 0;
      else if (fft_start)               bm_t <= 1;
      else if (bm_t != 0 && bm_t < 100) bm_t <= bm_t + 1;
   end

   always @(negedge clk) if (fft_start) start_cnt <= start_cnt + 1;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic next_cycle;
      @(posedge clk);
      #1;
   endtask

   task automatic load_frame(input int start_k, input int stop_k, input int mode);
      int k;
      int guard;
      logic [7:0] e;
      k = start_k;
      guard = 0;
      while (k < stop_k && guard < 200) begin
         in_valid = (mode == 0) ? 1'b1 : 1'($urandom_range(0, 3) != 0);
         in_data  = (mode == 0) ? DATA_W'(k + 1) : DATA_W'($urandom);
         e = in_valid ? (8'd1 << k) : 8'd0;
         @(negedge clk);
         check("load_ready", in_ready, 1'b1);
         check("load_busy", busy, k != 0);
         check("wr_en", x_wr_en, e);
         check("wr_data", x_wr_data, in_data);
         check("rev_wr_en", rev_x_wr_en, e);
         check("rev_wr_data", rev_x_wr_data, in_data);
         check("load_err", err, exp_err);
         check("load_out_valid", out_valid, 1'b0);
         if (in_valid) k++;
         guard++;
         next_cycle();
      end
      in_valid = 1'b0;
      check("load_count", k, stop_k);
   endtask

   task automatic launch_check;
      in_valid = 1'($urandom_range(0, 1));
      in_data  = DATA_W'($urandom);
      @(negedge clk);
      check("launch_start", fft_start, 1'b1);
      check("launch_ready", in_ready, 1'b0);
      check("launch_wr_en", x_wr_en, 8'h00);
      check("launch_busy", busy, 1'b1);
      next_cycle();
   endtask

   task automatic sb_sample(input int cyc, output bit last_seen);
      logic [W2-1:0] e;
      last_seen = 1'b0;
      if (stall_prev) begin
         check("stall_valid", out_valid, 1'b1);
         check("stall_data", out_data, data_prev);
         check("stall_rev_data", rev_out_data, rev_data_prev);
      end
      if (out_valid && out_ready) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL extra_beat: got data %0h expected no beat", out_data);
         end else begin
            beat++;
            e = exp_q.pop_front();
            check("out_data", out_data, e);
            check("out_last", out_last, beat == 8);
            e = exp_rev_q.pop_front();
            check("rev_out_data", rev_out_data, e);
            check("rev_out_last", rev_out_last, beat == 8);
            if (beat == 1) first_cyc = cyc;
            if (beat == 8) begin
               last_cyc  = cyc;
               last_seen = 1'b1;
            end
         end
      end
      stall_prev    = out_valid && !out_ready;
      data_prev     = out_data;
      rev_data_prev = rev_out_data;
   endtask

   task automatic unload(input int ready_mode, input bit check_span);
      bit         done;
      int         cyc;
      logic [3:0] pat;
      logic [2:0] kb;
      pat = 4'b1001;
      done = 1'b0;
      cyc = 0;
      beat = 0;
      stall_prev = 1'b0;
      for (int k = 0; k < 8; k++) begin
         kb = 3'(k);
         exp_q.push_back(bin_tbl[kb]);
         exp_rev_q.push_back(bin_tbl[{kb[0], kb[1], kb[2]}]);
      end
      while (!done && cyc < 400) begin
         case (ready_mode)
            0:       out_ready = 1'b1;
            1:       out_ready = pat[cyc % 4];
            default: out_ready = 1'($urandom_range(0, 1));
         endcase
         in_valid = 1'($urandom_range(0, 1));
         in_data  = DATA_W'($urandom);
         @(negedge clk);
         check("unload_ready", in_ready, 1'b0);
         check("unload_wr_en", x_wr_en, 8'h00);
         check("unload_busy", busy, 1'b1);
         sb_sample(cyc, done);
         cyc++;
         next_cycle();
      end
      out_ready = 1'b0;
      in_valid  = 1'b0;
      check("unload_done", done, 1'b1);
      if (check_span) check("beat_span", last_cyc - first_cyc, 7);
      @(negedge clk);
      check("idle_ready", in_ready, 1'b1);
      check("idle_busy", busy, 1'b0);
      check("idle_out_valid", out_valid, 1'b0);
      check("idle_err", err, exp_err);
      check("rev_idle_ready", rev_in_ready, 1'b1);
      check("rev_idle_busy", rev_busy, 1'b0);
      check("rev_idle_err", rev_err, exp_err);
      check("rev_idle_start", rev_fft_start, 1'b0);
      check("rev_idle_valid", rev_out_valid, 1'b0);
      check("exp_q_empty", exp_q.size(), 0);
      check("start_pulses", start_cnt - frame_base, 1);
      exp_q.delete();
      exp_rev_q.delete();
      next_cycle();
   endtask

   task automatic run_frame(input int load_mode, input int ready_mode);
      frame_base = start_cnt;
      load_frame(0, 8, load_mode);
      launch_check();
      unload(ready_mode, 1'b0);
   endtask

   initial begin
      vec_t vecs [6];
      vecs[0] = '{1'b0, 16'h1234, 1'b0, 8'h00, 1'b1, 1'b0};
      vecs[1] = '{1'b0, 16'h0000, 1'b1, 8'h00, 1'b1, 1'b0};
      vecs[2] = '{1'b1, 16'h0001, 1'b0, 8'h01, 1'b1, 1'b0};
      vecs[3] = '{1'b0, 16'h5555, 1'b1, 8'h00, 1'b1, 1'b1};
      vecs[4] = '{1'b1, 16'h0002, 1'b1, 8'h02, 1'b1, 1'b1};
      vecs[5] = '{1'b1, 16'h0003, 1'b0, 8'h04, 1'b1, 1'b1};

      rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
      force_busy = 1'b0; busy_mode = 0; rise_dly = 2; exp_err = 1'b0;
      for (int k = 0; k < 8; k++) bin_tbl[k] = W2'(k * 32'h0101);
      repeat (2) next_cycle();
      rst = 1'b0;
      @(negedge clk);
      check("rst_ready", in_ready, 1'b1);
      check("rst_busy", busy, 1'b0);
      check("rst_err", err, 1'b0);
      check("rst_start", fft_start, 1'b0);
      check("rst_out_valid", out_valid, 1'b0);
      check("rst_out_last", out_last, 1'b0);
      check("rst_out_data", out_data, 32'h0);
      check("rst_wr_en", x_wr_en, 8'h00);
      check("rst_res_sel", res_sel, 3'd0);
      next_cycle();

      // Frame 1: table-driven start of load (gaps, busy ignored), samples 1..8, full-rate unload
      frame_base = start_cnt;
      for (int i = 0; i < 6; i++) begin
         in_valid   = vecs[i].in_valid;
         in_data    = vecs[i].in_data;
         force_busy = vecs[i].force_busy;
         @(negedge clk);
         check("vec_wr_en", x_wr_en, vecs[i].exp_wr_en);
         check("vec_ready", in_ready, vecs[i].exp_ready);
         check("vec_busy", busy, vecs[i].exp_busy);
         next_cycle();
      end
      force_busy = 1'b0;
      load_frame(3, 8, 0);
      launch_check();
      unload(0, 1'b1);

      // Frame 2: gapless load, ready pattern 1,0,0,1
      run_frame(0, 1);

      // Busy rising at the last allowed cycle, then at the earliest
      rise_dly = START_TIMEOUT;
      run_frame(1, 2);
      rise_dly = 1;
      run_frame(1, 0);

      // Randomized frames
      for (int f = 0; f < 6; f++) begin
         rise_dly = $urandom_range(1, 2);
         for (int k = 0; k < 8; k++) bin_tbl[k] = W2'({$urandom, $urandom});
         run_frame(1, 2);
      end

      // Start timeout: busy never rises
      busy_mode = 1;
      frame_base = start_cnt;
      load_frame(0, 8, 1);
      for (int i = 0; i <= START_TIMEOUT + 1; i++) begin
         in_valid = (i <= START_TIMEOUT);
         in_data  = DATA_W'($urandom);
         @(negedge clk);
         check("to_start", fft_start, i == 0);
         check("to_err", err, i == START_TIMEOUT + 1);
         check("to_ready", in_ready, i == START_TIMEOUT + 1);
         check("to_wr_en", x_wr_en, 8'h00);
         check("to_out_valid", out_valid, 1'b0);
         next_cycle();
      end
      in_valid  = 1'b0;
      busy_mode = 0;
      exp_err   = 1'b1;
      check("to_start_pulses", start_cnt - frame_base, 1);

      // err stays set through a normal frame
      rise_dly = 2;
      run_frame(1, 2);

      // Reset after 5 samples, then a fresh frame from x_0
      load_frame(0, 5, 1);
      rst = 1'b1;
      repeat (2) next_cycle();
      rst = 1'b0;
      exp_err = 1'b0;
      @(negedge clk);
      check("mid_rst_err", err, 1'b0);
      check("mid_rst_ready", in_ready, 1'b1);
      check("mid_rst_busy", busy, 1'b0);
      check("mid_rst_out_valid", out_valid, 1'b0);
      next_cycle();
      run_frame(1, 2);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
